// File: rtl/video_stream_pkg.sv
// Shared definitions for the video stream stages: framer states, error bit
// positions and the default frame geometry used by the framer and the filter.
package video_stream_pkg;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_PASS = 2'd1,
    ST_PAD  = 2'd2,
    ST_DROP = 2'd3
  } framer_state_t;

  localparam int ERR_NO_SOF    = 0;
  localparam int ERR_SHORT     = 1;
  localparam int ERR_LONG      = 2;
  localparam int ERR_EARLY_SOF = 3;

  localparam int DEF_DATA_WIDTH   = 24;
  localparam int DEF_FRAME_WIDTH  = 20;
  localparam int DEF_FRAME_HEIGHT = 10;

  function automatic logic [3:0] err_pulse(input int idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/stream_video_framer_if.sv
// AXI4-Stream video bundle (pixel, SOF on tuser, EOL on tlast).
interface stream_video_framer_if
  import video_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tuser;
  logic                  tlast;

  // A beat transfers on a rising clk edge where tvalid && tready. Once tvalid
  // is high the master holds tdata/tuser/tlast stable until that transfer;
  // tready may depend combinationally on the offered beat.
  modport master (output tdata, tvalid, tuser, tlast, input tready);
  modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/video_axis_out_reg.sv
// Single-entry AXI4-Stream output register. 'load' writes a new beat; the
// caller may only load while 'free' is high.
module video_axis_out_reg #(
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] ld_tdata,
  input  logic                  ld_tuser,
  input  logic                  ld_tlast,
  output logic                  free,
  stream_video_framer_if.master m_axis
);

  assign free = !m_axis.tvalid || m_axis.tready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= '0;
      m_axis.tuser  <= 1'b0;
      m_axis.tlast  <= 1'b0;
    end else if (load) begin
      m_axis.tvalid <= 1'b1;
      m_axis.tdata  <= ld_tdata;
      m_axis.tuser  <= ld_tuser;
      m_axis.tlast  <= ld_tlast;
    end else if (m_axis.tready) begin
      m_axis.tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_video_framer.sv
// Frame-conformance stage: regenerates SOF/EOL from output position, pads
// short lines, truncates long lines and discards input until the first SOF.
module stream_video_framer
  import video_stream_pkg::*;
#(
  parameter int                    DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int                    FRAME_WIDTH  = DEF_FRAME_WIDTH,
  parameter int                    FRAME_HEIGHT = DEF_FRAME_HEIGHT,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE    = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  stream_video_framer_if.slave  s_axis_video,
  stream_video_framer_if.master m_axis_video,
  output logic [3:0]            err,
  output framer_state_t         state_dbg
);

  localparam int CW = $clog2(FRAME_WIDTH);
  localparam int RW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(FRAME_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_HEIGHT - 1);

  framer_state_t         state, state_nxt;
  logic [CW-1:0]         col, col_nxt;
  logic [RW-1:0]         row, row_nxt;
  logic [3:0]            err_nxt;
  logic                  free, rdy, accept, at_origin, at_eol;
  logic                  load, restart, ld_tuser, ld_tlast;
  logic [DATA_WIDTH-1:0] ld_tdata;

  assign at_origin = (row == '0) && (col == '0);
  assign at_eol    = (col == COL_LAST);
  assign state_dbg = state;

  // SYNC/DROP discard freely; only a SOF pixel (which gets loaded) must wait
  // for the output register so a held beat is never overwritten.
  always_comb begin
    rdy = 1'b0;
    case (state)
      ST_SYNC, ST_DROP: rdy = free || !s_axis_video.tuser;
      ST_PASS:          rdy = free;
      default:          rdy = 1'b0;
    endcase
  end

  assign s_axis_video.tready = reset && rdy;
  assign accept              = s_axis_video.tvalid && s_axis_video.tready;

  always_comb begin
    state_nxt = state;
    err_nxt   = '0;
    load      = 1'b0;
    restart   = 1'b0;
    ld_tdata  = s_axis_video.tdata;
    case (state)
      ST_SYNC: begin
        if (accept && s_axis_video.tuser) begin
          load      = 1'b1;
          restart   = 1'b1;
          state_nxt = ST_PASS;
        end
      end
      ST_PASS: begin
        if (accept) begin
          if (s_axis_video.tuser) begin
            // SOF wins over EOL; only a SOF at the origin can also end a short line.
            load    = 1'b1;
            restart = 1'b1;
            if (!at_origin) begin
              err_nxt = err_pulse(ERR_EARLY_SOF);
            end else if (s_axis_video.tlast) begin
              err_nxt   = err_pulse(ERR_SHORT);
              state_nxt = ST_PAD;
            end
          end else if (at_origin) begin
            err_nxt   = err_pulse(ERR_NO_SOF);
            state_nxt = ST_SYNC;
          end else begin
            load = 1'b1;
            if (s_axis_video.tlast && !at_eol) begin
              err_nxt   = err_pulse(ERR_SHORT);
              state_nxt = ST_PAD;
            end else if (!s_axis_video.tlast && at_eol) begin
              err_nxt   = err_pulse(ERR_LONG);
              state_nxt = ST_DROP;
            end
          end
        end
      end
      ST_PAD: begin
        if (free) begin
          load     = 1'b1;
          ld_tdata = PAD_VALUE;
          if (at_eol) state_nxt = ST_PASS;
        end
      end
      ST_DROP: begin
        if (accept) begin
          if (s_axis_video.tuser) begin
            load      = 1'b1;
            restart   = 1'b1;
            err_nxt   = err_pulse(ERR_EARLY_SOF);
            state_nxt = ST_PASS;
          end else if (s_axis_video.tlast) begin
            state_nxt = ST_PASS;
          end
        end
      end
      default: state_nxt = ST_SYNC;
    endcase
  end

  // A restarted beat is the new origin; FRAME_WIDTH >= 2 so it is never an EOL.
  assign ld_tuser = restart || at_origin;
  assign ld_tlast = !restart && at_eol;

  always_comb begin
    col_nxt = col;
    row_nxt = row;
    if (load) begin
      if (restart) begin
        col_nxt = CW'(1);
        row_nxt = '0;
      end else if (at_eol) begin
        col_nxt = '0;
        row_nxt = (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col_nxt = col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_SYNC;
      col   <= '0;
      row   <= '0;
      err   <= '0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
      err   <= err_nxt;
    end
  end

  video_axis_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .ld_tdata (ld_tdata),
    .ld_tuser (ld_tuser),
    .ld_tlast (ld_tlast),
    .free     (free),
    .m_axis   (m_axis_video)
  );

endmodule

// File: tb/tb_stream_video_framer.sv
// Bench for stream_video_framer: randomized pixels through directed frame
// scenarios, scored against a frame-position reference model.
module tb_stream_video_framer;
  import video_stream_pkg::*;

  localparam int DW = 24;
  localparam int W  = 20;
  localparam int H  = 10;
  localparam logic [DW-1:0] PAD = 24'hA5C3E1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  stream_video_framer_if #(.DATA_WIDTH(DW)) s_if ();
  stream_video_framer_if #(.DATA_WIDTH(DW)) m_if ();
  logic [3:0]    err;
  framer_state_t state_dbg;

  stream_video_framer #(
    .DATA_WIDTH(DW), .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .PAD_VALUE(PAD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s_axis_video (s_if),
    .m_axis_video (m_if),
    .err          (err),
    .state_dbg    (state_dbg)
  );

  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;
  int beats_seen = 0;
  int err_seen[4] = '{default: 0};
  bit gap_en = 1'b0;
  bit bp_en  = 1'b0;

  logic [DW+1:0] exp_q[$];
  logic [3:0]    exp_err_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the output position as a single index into the frame.
  bit m_locked   = 1'b0;
  bit m_dropping = 1'b0;
  int m_pos      = 0;

  function automatic void model_emit(input logic [DW-1:0] d);
    exp_q.push_back({(m_pos == 0), (m_pos % W == W - 1), d});
    m_pos = (m_pos + 1) % (W * H);
  endfunction

  function automatic void model_beat(input logic [DW-1:0] d, input logic u, input logic l);
    int c;
    c = m_pos % W;
    if (!m_locked) begin
      if (u) begin
        m_locked = 1'b1;
        m_pos    = 0;
        model_emit(d);
      end
    end else if (m_dropping) begin
      if (u) begin
        exp_err_q.push_back(4'b1000);
        m_dropping = 1'b0;
        m_pos      = 0;
        model_emit(d);
      end else if (l) begin
        m_dropping = 1'b0;
      end
    end else if (u && m_pos != 0) begin
      exp_err_q.push_back(4'b1000);
      m_pos = 0;
      model_emit(d);
    end else if (!u && m_pos == 0) begin
      exp_err_q.push_back(4'b0001);
      m_locked = 1'b0;
    end else begin
      model_emit(d);
      if (l && c < W - 1) begin
        exp_err_q.push_back(4'b0010);
        for (int k = 0; k < W - 1 - c; k++) model_emit(PAD);
      end else if (!l && c == W - 1) begin
        exp_err_q.push_back(4'b0100);
        m_dropping = 1'b1;
      end
    end
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      exp_err_q.delete();
      m_locked   = 1'b0;
      m_dropping = 1'b0;
      m_pos      = 0;
      check("reset_outputs",
            {m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata, s_if.tready, err}, '0);
    end else begin
      if (s_if.tvalid && s_if.tready) model_beat(s_if.tdata, s_if.tuser, s_if.tlast);
      if (m_if.tvalid && m_if.tready) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL out_extra_beat: observed %0h expected none",
                 {m_if.tuser, m_if.tlast, m_if.tdata});
        end
        if (exp_q.size() > 0) check("out_beat", {m_if.tuser, m_if.tlast, m_if.tdata}, exp_q.pop_front());
        beats_seen++;
      end
      if (err !== 4'b0) begin
        check("err_onehot", 64'($onehot(err)), 64'd1);
        checks++;
        assert (exp_err_q.size() > 0) else begin
          errors++;
          $error("FAIL err_unexpected: observed %0h expected none", err);
        end
        if (exp_err_q.size() > 0) check("err_code", err, exp_err_q.pop_front());
        for (int i = 0; i < 4; i++) err_seen[i] += int'(err[i]);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    m_if.tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- driver tasks ----------------
  function automatic logic [DW-1:0] rnd_pix();
    logic [31:0] r;
    r = $urandom();
    return r[DW-1:0];
  endfunction

  task automatic send_beat(input logic [DW-1:0] d, input logic u, input logic l);
    logic acc;
    int   n;
    if (gap_en && $urandom_range(0, 3) == 0) begin
      @(posedge clk);
      #1;
    end
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tuser  = u;
    s_if.tlast  = l;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = s_if.tready;
      if (!acc) stall_cnt++;
      @(posedge clk);
      #1;
      n++;
    end
    check("accept_in_budget", acc, 1'b1);
    s_if.tvalid = 1'b0;
  endtask

  task automatic send_line(input int len, input logic sof);
    for (int i = 0; i < len; i++) send_beat(rnd_pix(), sof && (i == 0), i == len - 1);
  endtask

  task automatic send_frame(input int short_row, input int short_len,
                            input int long_row, input int long_len);
    for (int r = 0; r < H; r++)
      send_line((r == short_row) ? short_len : (r == long_row) ? long_len : W, r == 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic check_errs(input string tag, input int e0[4], input logic [3:0] mask);
    for (int i = 0; i < 4; i++) check(tag, err_seen[i] - e0[i], int'(mask[i]));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int b0;
    int e0[4];
    logic [DW-1:0] d0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tuser  = 1'b0;
    s_if.tlast  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", m_if.tvalid, 1'b0);
    check("rst_m_tdata", m_if.tdata, '0);
    check("rst_m_tuser", m_if.tuser, 1'b0);
    check("rst_m_tlast", m_if.tlast, 1'b0);
    check("rst_s_tready", s_if.tready, 1'b0);
    check("rst_err", err, 4'b0);
    check("rst_state", state_dbg, ST_SYNC);
    reset = 1'b1;
    #1;
    check("rdy_after_release", s_if.tready, 1'b1);
    @(posedge clk);
    #1;

    // garbage before the first SOF
    e0 = err_seen;
    stall_cnt = 0;
    for (int i = 0; i < 7; i++) send_beat(rnd_pix(), 1'b0, (i % 3) == 2);
    check("garbage_no_stall", stall_cnt, 0);
    check("garbage_state", state_dbg, ST_SYNC);
    check("garbage_no_output", m_if.tvalid, 1'b0);

    // clean frames with a one-cycle latency check on the first pixel
    b0 = beats_seen;
    d0 = rnd_pix();
    send_beat(d0, 1'b1, 1'b0);
    check("lat_tvalid", m_if.tvalid, 1'b1);
    check("lat_tuser", m_if.tuser, 1'b1);
    check("lat_tdata", m_if.tdata, d0);
    for (int i = 1; i < W * H; i++) send_beat(rnd_pix(), 1'b0, (i % W) == W - 1);
    send_frame(-1, 0, -1, 0);
    drain();
    check("clean_beats", beats_seen - b0, 2 * W * H);
    check("clean_no_stall", stall_cnt, 0);
    check_errs("clean_err_cnt", e0, 4'b0000);

    // short line: row 3 ends at col 14
    e0 = err_seen;
    b0 = beats_seen;
    stall_cnt = 0;
    send_frame(3, 15, -1, 0);
    drain();
    check("short_stalls", stall_cnt, W - 15);
    check("short_beats", beats_seen - b0, W * H);
    check_errs("short_err_cnt", e0, 4'b0010);

    // long line: row 5 carries 25 pixels
    e0 = err_seen;
    b0 = beats_seen;
    send_frame(-1, 0, 5, 25);
    drain();
    check("long_beats", beats_seen - b0, W * H);
    check_errs("long_err_cnt", e0, 4'b0100);

    // early SOF at row 4 col 8
    e0 = err_seen;
    b0 = beats_seen;
    for (int r = 0; r < 4; r++) send_line(W, r == 0);
    for (int c = 0; c < 8; c++) send_beat(rnd_pix(), 1'b0, 1'b0);
    send_frame(-1, 0, -1, 0);
    drain();
    check("early_beats", beats_seen - b0, 4 * W + 8 + W * H);
    check_errs("early_err_cnt", e0, 4'b1000);

    // missing SOF after a complete frame
    e0 = err_seen;
    b0 = beats_seen;
    for (int i = 0; i < 3; i++) send_beat(rnd_pix(), 1'b0, 1'b0);
    check("nosof_state", state_dbg, ST_SYNC);
    send_frame(-1, 0, -1, 0);
    drain();
    check("nosof_beats", beats_seen - b0, W * H);
    check_errs("nosof_err_cnt", e0, 4'b0001);

    // backpressure, input gaps, then reset mid-line
    bp_en  = 1'b1;
    gap_en = 1'b1;
    send_frame(-1, 0, -1, 0);
    send_frame(2, 6, 7, 23);
    send_line(W, 1'b1);
    for (int c = 0; c < 9; c++) send_beat(rnd_pix(), 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    check("midrst_m_tvalid", m_if.tvalid, 1'b0);
    check("midrst_m_tdata", m_if.tdata, '0);
    check("midrst_s_tready", s_if.tready, 1'b0);
    check("midrst_err", err, 4'b0);
    check("midrst_state", state_dbg, ST_SYNC);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_rdy_release", s_if.tready, 1'b1);
    e0 = err_seen;
    b0 = beats_seen;
    for (int c = 9; c < W; c++) send_beat(rnd_pix(), 1'b0, c == W - 1);
    send_frame(-1, 0, -1, 0);
    send_frame(-1, 0, -1, 0);
    bp_en = 1'b0;
    drain();
    check("relock_beats", beats_seen - b0, 2 * W * H);
    check_errs("relock_err_cnt", e0, 4'b0000);
    check("err_queue_empty", exp_err_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/stream_video_framer.md
# stream_video_framer

Frame-conformance stage placed directly upstream of `stream_video_filter`. Guarantees that every frame reaching the filter has exactly FRAME_WIDTH pixels per line and FRAME_HEIGHT lines, with `tuser` on the first pixel only and `tlast` on the last pixel of each line. Malformed input is repaired: short lines are padded, long lines are truncated, and pixels before the first SOF are discarded. Error pulses report each repair.

## Interface
- DATA_WIDTH, 24, pixel width (RGB888).
- FRAME_WIDTH, 20, pixels per line, ≥2.
- FRAME_HEIGHT, 10, lines per frame, ≥1.
- PAD_VALUE, 24'h000000, pixel value inserted into short lines.

- clk  in  1  sole clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- s_axis_video_tdata  in  DATA_WIDTH  input pixel.
- s_axis_video_tvalid  in  1  input valid.
- s_axis_video_tready  out  1  input ready.
- s_axis_video_tuser  in  1  input SOF.
- s_axis_video_tlast  in  1  input EOL.
- m_axis_video_tdata  out  DATA_WIDTH  output pixel.
- m_axis_video_tvalid  out  1  output valid.
- m_axis_video_tready  in  1  output ready.
- m_axis_video_tuser  out  1  output SOF, regenerated.
- m_axis_video_tlast  out  1  output EOL, regenerated.
- err  out  4  one-cycle pulses: [0] missing SOF, [1] short line, [2] long line, [3] early SOF.

## Operation
- Output register: one entry (tdata/tuser/tlast/tvalid). Free when `!m_tvalid || m_tready`. Input accept = `s_tvalid && s_tready`.
- Counters: `col` 0..FRAME_WIDTH-1 and `row` 0..FRAME_HEIGHT-1 track the **output** position. They advance on every pixel loaded into the output register. `col` wraps to 0 and increments `row`. `row` wraps to 0 after FRAME_HEIGHT-1.
- Output `tuser` = (row==0 && col==0). Output `tlast` = (col==FRAME_WIDTH-1). Input tuser/tlast are never forwarded.
- States:
  - SYNC (reset state). `s_tready`=1. All input is dropped until an accepted pixel has tuser=1. That pixel is loaded as row0/col0 → PASS.
  - PASS. `s_tready` = output register free. Each accepted pixel is loaded.
    - Input tlast with col<FRAME_WIDTH-1 → PAD, err[1].
    - col==FRAME_WIDTH-1 without input tlast → DROP, err[2].
    - At row0/col0 with input tuser=0 → the pixel is dropped, state → SYNC, err[0].
    - Input tuser at any position other than row0/col0 → counters reset. The pixel is loaded as a new SOF (output tuser=1), err[3]. The previous frame is left truncated.
  - PAD. `s_tready`=0. Loads PAD_VALUE whenever the output register is free, until the pixel at col==FRAME_WIDTH-1 is loaded → PASS.
  - DROP. `s_tready`=1. Input is discarded, nothing is loaded. When the input tlast pixel is accepted → PASS. If an input tuser arrives in DROP, that pixel is loaded as a new SOF → PASS, err[3].
- Simultaneous events: tuser has priority over tlast. A pixel with both set at a non-origin position is handled as early SOF only; the line restarts and no PAD follows.
- Only one `err` bit is asserted per cycle, each for one clk.

## Timing
- Latency: 1 cycle from input accept to `m_tvalid`.
- Throughput: 1 pixel/clk in PASS with `m_tready`=1. PAD inserts FRAME_WIDTH-1-col bubbles on the input side.
- `m_tvalid`, once high, holds with stable tdata/tuser/tlast until `m_tready`.
- Reset asserted: `m_tvalid`=0, `m_tdata`=0, `m_tuser`=0, `m_tlast`=0, `s_tready`=0, `err`=0, col=row=0, state=SYNC.
- Reset mid-frame: the output register contents are lost. After release, the block resynchronises on the next input SOF.
- `s_tready` goes to 1 in the first cycle after reset release (SYNC).

## Structure
- Shared package `video_stream_pkg`: state enum (SYNC/PASS/PAD/DROP), err bit index constants, and default geometry constants shared with `stream_video_filter`.
- One sub-module, `video_axis_out_reg`: a single-entry AXI4-Stream output register with a load strobe, `free` flag and reset. The framer FSM and counters stay in the top module.

## Test plan
- Clean frames: W=20, H=10, continuous valid, `m_tready`=1. Output is identical to the input, 200 pixels/frame, tuser only on pixel 0, tlast on every 20th pixel, err stays 0, latency 1 clk.
- Garbage before SOF: 7 pixels with tuser=0, then a clean frame. The 7 pixels are dropped with `s_tready`=1 throughout, err[0] does not fire (state is SYNC), and the output frame is exact.
- Short line: line 3 has tlast at col 14. Output line 3 has input cols 0–14, then 5× PAD_VALUE, tlast on the 20th pixel. `s_tready`=0 for the 5 pad loads, err[1] pulses once.
- Long line: line 5 has 25 pixels. 20 are output with tlast on the 20th, 5 are dropped, err[2] pulses once, and line 6 is output intact.
- Early SOF at row 4 col 8. The output shows tuser on that pixel, the next frame counts 200 pixels from it, and err[3] pulses.
- Backpressure: `m_tready` toggles randomly 50%, and reset is pulsed low mid-line. No output beat is lost or duplicated while reset is high. After reset, all outputs are 0, then lock on the next SOF.
